// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the segment-to-ASCII inverse table.
// Bit order of seg_n is {g,f,e,d,c,b,a}; a 1 means the segment is dark.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK     = 7'b1111111;
    localparam logic [6:0] SEG_ALL       = 7'b0000000;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    typedef struct packed {
        logic       hit;
        logic [7:0] ascii;
    } seg7_dec_t;

    // Patterns shared by several glyphs decode once: digits over letters.
    function automatic seg7_dec_t seg7_to_ascii(input logic [6:0] seg_n);
        seg7_dec_t r;
        r.hit   = 1'b1;
        r.ascii = ASCII_UNKNOWN;
        case (seg_n)
            7'b1111111: r.ascii = 8'h20;
            7'b0111111: r.ascii = 8'h2D;
            7'b1000000: r.ascii = 8'h30;
            7'b1111001: r.ascii = 8'h31;
            7'b0100100: r.ascii = 8'h32;
            7'b0110000: r.ascii = 8'h33;
            7'b0011001: r.ascii = 8'h34;
            7'b0010010: r.ascii = 8'h35;
            7'b0000010: r.ascii = 8'h36;
            7'b1111000: r.ascii = 8'h37;
            7'b0000000: r.ascii = 8'h38;
            7'b0010000: r.ascii = 8'h39;
            7'b0001000: r.ascii = 8'h41;
            7'b0000011: r.ascii = 8'h42;
            7'b1000110: r.ascii = 8'h43;
            7'b0100001: r.ascii = 8'h44;
            7'b0000110: r.ascii = 8'h45;
            7'b0001110: r.ascii = 8'h46;
            7'b1000010: r.ascii = 8'h47;
            7'b0001001: r.ascii = 8'h48;
            7'b1001111: r.ascii = 8'h49;
            7'b1100001: r.ascii = 8'h4A;
            7'b1000111: r.ascii = 8'h4C;
            7'b0101011: r.ascii = 8'h4E;
            7'b0001100: r.ascii = 8'h50;
            7'b0101111: r.ascii = 8'h52;
            7'b0000111: r.ascii = 8'h54;
            7'b1000001: r.ascii = 8'h55;
            7'b1010101: r.ascii = 8'h57;
            7'b0010001: r.ascii = 8'h59;
            default: begin
                r.hit   = 1'b0;
                r.ascii = ASCII_UNKNOWN;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_ascii_decode.sv
// Combinational segment-pattern to ASCII decoder.
// Thin wrapper so the table lives in one place (the package).
module seg7_ascii_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       hit,
    output logic [7:0] ascii
);

    seg7_dec_t dec;

    always_comb begin
        dec   = seg7_to_ascii(seg_n);
        hit   = dec.hit;
        ascii = dec.ascii;
    end

endmodule

// File: rtl/seg7_ascii_capture.sv
// Snoops a scanned active-low 7-seg bus, debounces and decodes each digit,
// filters repeats against a shadow copy and queues {pos,char} for a consumer.
module seg7_ascii_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [6:0]                    seg_n,
    input  logic [NUM_DIGITS-1:0]         dig_sel,
    input  logic                          resync,
    input  logic                          clear_flags,
    output logic                          char_valid,
    input  logic                          char_ready,
    output logic [7:0]                    char_data,
    output logic [$clog2(NUM_DIGITS)-1:0] char_pos,
    output logic                          overflow,
    output logic                          decode_err
);

    localparam int POS_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int EW    = POS_W + 8;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [AW:0]      FULL_N  = (AW + 1)'(FIFO_DEPTH);

    logic [NUM_DIGITS-1:0] samp_sel;
    logic [6:0]            samp_seg;
    logic [CNT_W-1:0]      cnt;
    logic                  one_hot;
    logic                  same;
    logic                  capture;
    logic [POS_W-1:0]      pos;
    logic                  dec_hit;
    logic [7:0]            dec_ascii;

    logic [7:0]            shadow [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] shadow_v;
    logic                  is_new;

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  full;
    logic                  pop;
    logic                  push_req;
    logic                  push;
    logic                  drop;

    assign one_hot = (dig_sel != '0) &&
                     ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
    assign same    = (dig_sel == samp_sel) && (seg_n == samp_seg);

    // Fires on the edge where the counter would step from ARM to MAX,
    // so a saturated dwell never captures twice.
    assign capture = one_hot && same && (cnt == CNT_ARM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_sel <= '0;
            samp_seg <= SEG_BLANK;
            cnt      <= '0;
        end else begin
            samp_sel <= dig_sel;
            samp_seg <= seg_n;
            if (!one_hot || !same)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        pos = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (samp_sel[i])
                pos = POS_W'(i);
    end

    seg7_ascii_decode u_decode (
        .seg_n (samp_seg),
        .hit   (dec_hit),
        .ascii (dec_ascii)
    );

    assign is_new   = !shadow_v[pos] || (shadow[pos] != dec_ascii);
    assign full     = (count == FULL_N);
    assign char_valid = (count != '0);
    assign pop      = char_valid && char_ready;
    assign push_req = capture && is_new;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_v <= '0;
            for (int i = 0; i < NUM_DIGITS; i++)
                shadow[i] <= '0;
        end else if (resync) begin
            shadow_v <= '0;
        end else if (push) begin
            shadow_v[pos] <= 1'b1;
            shadow[pos]   <= dec_ascii;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {pos, dec_ascii};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign char_data = mem[rd_ptr][7:0];
    assign char_pos  = mem[rd_ptr][EW-1:8];

    // Set wins over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            decode_err <= 1'b0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            else if (clear_flags)
                overflow <= 1'b0;
            if (capture && !dec_hit)
                decode_err <= 1'b1;
            else if (clear_flags)
                decode_err <= 1'b0;
        end
    end

endmodule
